// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the data-memory responder.
// Lane selection follows the RISC-V funct3 size code.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Byte-enable mask; halfword and word accesses align down to their natural boundary.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size[1:0])
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] size, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] d;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (size[1:0])
            2'b00:   d = size[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   d = size[2] ? {16'd0, half} : {{16{half[15]}}, half};
            default: d = word;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lane);
        return ((size[1:0] == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_wait_resp_if.sv
// Load/store handshake bundle between the M stage (master) and the data memory (slave).
interface dmem_wait_resp_if #(
    parameter int AW = 32
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          busy;
    logic          err;

    modport master (output req, we, addr, size, wdata, input rdata, ack, busy, err);
    modport slave  (input req, we, addr, size, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage split into four byte lanes: per-lane synchronous write, combinational read.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (be[gi]) begin
                lane_mem[idx] <= wdata[8*gi +: 8];
            end
        end

        assign rdata[8*gi +: 8] = lane_mem[idx];
    end
endmodule

// File: rtl/dmem_wait_resp.sv
// Data-memory responder with req/ack handshake and WAIT_CYCLES wait states.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_wait_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_wait_resp_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [2:0]    size_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;

    logic          eff_we;
    logic [AW-1:0] eff_addr;
    logic [2:0]    eff_size;
    logic [31:0]   eff_wdata;
    logic          commit;
    logic          misalign;
    logic [3:0]    be;
    logic [31:0]   rd_word;
    logic          unused_addr_hi;

    // With zero wait states the commit edge is the capture edge, so use the live request.
    assign eff_we    = (state_reg == IDLE) ? bus.we    : we_reg;
    assign eff_addr  = (state_reg == IDLE) ? bus.addr  : addr_reg;
    assign eff_size  = (state_reg == IDLE) ? bus.size  : size_reg;
    assign eff_wdata = (state_reg == IDLE) ? bus.wdata : wdata_reg;

    assign unused_addr_hi = ^eff_addr[AW-1:IW+2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state_next == ACK) && (state_reg != ACK);

`ifdef DMEM_MISALIGN_CHK_EN
    assign misalign = is_misaligned(eff_size, eff_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Reset on the commit edge discards the pending store.
    assign be = (commit && eff_we && !misalign && !rst) ? lane_mask(eff_size, eff_addr[1:0]) : 4'b0000;

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .be    (be),
        .idx   (eff_addr[IW+1:2]),
        .wdata (store_lanes(eff_size, eff_wdata)),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            size_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && bus.req) begin
                we_reg    <= bus.we;
                addr_reg  <= bus.addr;
                size_reg  <= bus.size;
                wdata_reg <= bus.wdata;
            end
            if (commit) begin
                rdata_reg <= misalign ? 32'd0 : load_extract(eff_size, eff_addr[1:0], rd_word);
                err_reg   <= misalign;
            end
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.ack   = (state_reg == ACK);
    assign bus.busy  = (state_reg != IDLE);
    assign bus.err   = (state_reg == ACK) && err_reg;

endmodule
